// File: rtl/memorio_bridge.sv
// memorio_bridge: memory/IO bridge for the single-cycle MIPS CPU.
// Routes loads/stores to data memory or to the board peripherals (LEDs,
// debounced switches, eight-digit multiplexed 7-segment display).
// Optional build macro SEG_LEAD_ZERO_BLANK_EN blanks leading zero digits.
module memorio_bridge #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000,
  parameter logic [16:0] SCAN_DIV        = 17'd100000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        io_read,
  input  logic        io_write,
  input  logic [31:0] addr_in,
  input  logic [31:0] m_rdata,
  input  logic [31:0] r_wdata,
  input  logic [23:0] switch_in,
  output logic [31:0] addr_out,
  output logic [31:0] r_rdata,
  output logic [31:0] write_data,
  output logic [23:0] led_out,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_out
);

  localparam logic [31:0] LED_ADDR = 32'hFFFF_FC60;
  localparam logic [31:0] SW_ADDR  = 32'hFFFF_FC70;
  localparam logic [31:0] SEG_ADDR = 32'hFFFF_FC80;

  logic [23:0] led_r;
  logic [31:0] seg_val_r;
  logic [23:0] sw_db_r;
  logic [23:0] sync1_r;
  logic [23:0] sync2_r;
  logic [23:0] cand_r;
  logic [19:0] db_cnt_r;
  logic [16:0] scan_cnt_r;
  logic [2:0]  dig_r;

  logic [19:0] db_cnt_next_s;
  logic        db_stable_s;
  logic [3:0]  nibble_s;
  logic        blank_s;

  // Hex digit to active-low segment pattern, decimal point off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'h0:    pat = 8'hC0;
      4'h1:    pat = 8'hF9;
      4'h2:    pat = 8'hA4;
      4'h3:    pat = 8'hB0;
      4'h4:    pat = 8'h99;
      4'h5:    pat = 8'h92;
      4'h6:    pat = 8'h82;
      4'h7:    pat = 8'hF8;
      4'h8:    pat = 8'h80;
      4'h9:    pat = 8'h90;
      4'hA:    pat = 8'h88;
      4'hB:    pat = 8'h83;
      4'hC:    pat = 8'hC6;
      4'hD:    pat = 8'hA1;
      4'hE:    pat = 8'h86;
      4'hF:    pat = 8'h8E;
      default: pat = 8'hFF;
    endcase
    return pat;
  endfunction

  assign addr_out = addr_in;
  assign led_out  = led_r;

  // Store data reaches data memory only during a memory store.
  always_comb begin
    write_data = 32'h0;
    if (mem_write) begin
      write_data = r_wdata;
    end else begin
      write_data = 32'h0;
    end
  end

  // Load data mux; a memory load takes priority over an IO load.
  always_comb begin
    r_rdata = 32'h0;
    if (mem_read) begin
      r_rdata = m_rdata;
    end else if (io_read && (addr_in == SW_ADDR)) begin
      r_rdata = {8'h0, sw_db_r};
    end else if (io_read && (addr_in == SEG_ADDR)) begin
      r_rdata = seg_val_r;
    end else begin
      r_rdata = 32'h0;
    end
  end

  // IO register writes; unmapped and switch-address writes fall through.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      led_r     <= 24'h0;
      seg_val_r <= 32'h0;
    end else begin
      if (io_write && (addr_in == LED_ADDR)) begin
        led_r <= r_wdata[23:0];
      end
      if (io_write && (addr_in == SEG_ADDR)) begin
        seg_val_r <= r_wdata;
      end
    end
  end

  // Debounce counter: restart on any change, saturate at the accept point.
  always_comb begin
    db_stable_s   = (sync2_r == cand_r);
    db_cnt_next_s = 20'h0;
    if (!db_stable_s) begin
      db_cnt_next_s = 20'h0;
    end else if (db_cnt_r == (DEBOUNCE_CYCLES - 20'd1)) begin
      db_cnt_next_s = db_cnt_r;
    end else begin
      db_cnt_next_s = db_cnt_r + 20'd1;
    end
  end

  // Switch synchronizer, candidate latch and debounced value.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_r  <= 24'h0;
      sync2_r  <= 24'h0;
      cand_r   <= 24'h0;
      db_cnt_r <= 20'h0;
      sw_db_r  <= 24'h0;
    end else begin
      sync1_r  <= switch_in;
      sync2_r  <= sync1_r;
      cand_r   <= sync2_r;
      db_cnt_r <= db_cnt_next_s;
      if (db_stable_s && (db_cnt_next_s == (DEBOUNCE_CYCLES - 20'd1))) begin
        sw_db_r <= cand_r;
      end
    end
  end

  // Display scan: dwell SCAN_DIV cycles per digit, digit index wraps 7 -> 0.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      scan_cnt_r <= 17'h0;
      dig_r      <= 3'h0;
    end else if (scan_cnt_r == (SCAN_DIV - 17'd1)) begin
      scan_cnt_r <= 17'h0;
      dig_r      <= dig_r + 3'd1;
    end else begin
      scan_cnt_r <= scan_cnt_r + 17'd1;
    end
  end

  // Digit enable and segment decode for the currently scanned digit.
  always_comb begin
    nibble_s = seg_val_r[{dig_r, 2'b00} +: 4];
`ifdef SEG_LEAD_ZERO_BLANK_EN
    blank_s  = (dig_r != 3'd0) && ((seg_val_r >> {dig_r, 2'b00}) == 32'h0);
`else
    blank_s  = 1'b0;
`endif
    if (blank_s) begin
      seg_an = 8'hFF;
    end else begin
      seg_an = ~(8'h01 << dig_r);
    end
    seg_out = hex_to_seg(nibble_s);
  end

endmodule

// File: doc/memorio_bridge.md
Name: memorio_bridge

Overview:
- Memory/IO bridge directly downstream of the main control unit in the single-cycle MIPS CPU.
- Consumes mem_read/mem_write/io_read/io_write and the ALU address; routes loads and stores to data memory or to board peripherals.
- Owns the peripheral state:
  - LED register
  - debounced switch register
  - eight-digit multiplexed 7-segment display

Parameters:
DEBOUNCE_CYCLES, 20'd1000000, consecutive stable cycles before a switch change is accepted (min 2)
SCAN_DIV, 17'd100000, clock cycles each 7-seg digit is lit (min 2)

Ports:
clock  in  1  system clock, all state updates on rising edge
reset_n  in  1  synchronous active-low reset
mem_read  in  1  load from data memory (from control unit)
mem_write  in  1  store to data memory (from control unit)
io_read  in  1  load from IO space (from control unit)
io_write  in  1  store to IO space (from control unit)
addr_in  in  32  ALU result / effective address
m_rdata  in  32  data memory read data
r_wdata  in  32  register file rt value (store data)
switch_in  in  24  raw board switches, asynchronous
addr_out  out  32  address to data memory, equal to addr_in
r_rdata  out  32  load data to writeback mux
write_data  out  32  store data to data memory
led_out  out  24  board LEDs, active-high
seg_an  out  8  digit enables, active-low, bit0 = rightmost digit
seg_out  out  8  segments, active-low, bit7 = dp, bits6:0 = g..a

Behaviour:
- IO space is addr_in[31:10] = 22'h3FFFFF. Registers are decoded on the full word address:
  - 0xFFFFFC60: LED (write)
  - 0xFFFFFC70: switches (read)
  - 0xFFFFFC80: 7-seg value (read/write)
- addr_out = addr_in, combinational.
- write_data = r_wdata when mem_write is 1; otherwise 0.
- r_rdata (combinational):
  - mem_read = 1: m_rdata.
  - io_read = 1 and address is the switch register: {8'h0, sw_db}.
  - io_read = 1 and address is the 7-seg register: seg_val.
  - Any other IO address, or no read: 32'h0.
  - If mem_read and io_read are both 1, mem_read wins.
- IO writes take effect on the rising edge where io_write = 1 and the address matches:
  - LED: led_out <= r_wdata[23:0].
  - 7-seg: seg_val <= r_wdata.
  - Unmapped IO writes and writes to the switch address are ignored.
  - Effect is visible in the next cycle, so a read in the cycle after a write returns the new value.
- Switch path:
  - 2-flop synchronizer, then debounce.
  - The debounce counter resets to 0 whenever the synchronized value differs from the candidate latched last cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the value unchanged, sw_db <= candidate.
  - The counter saturates there; it must not wrap.
- Display scan:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit index dig (3 bits) increments modulo 8 (7 -> 0).
  - seg_an = ~(8'b1 << dig).
  - seg_out = hex pattern of seg_val[4*dig+3 : 4*dig] with dp off, i.e. bit7 = 1. Patterns: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
  - seg_an and seg_out are combinational from dig and seg_val.
- Reset (reset_n = 0 at a rising edge, including mid-scan or mid-debounce), all of these cleared to 0:
  - led_out
  - seg_val
  - sw_db
  - synchronizer flops
  - candidate
  - debounce counter
  - scan_cnt
  - dig
- Outputs during reset: seg_an = 8'hFE, seg_out = 8'hC0.
- A store held during reset is not performed.

Optional Feature:
- Macro SEG_LEAD_ZERO_BLANK_EN.
- Defined: digit dig is blanked (seg_an = 8'hFF for that slot) when dig > 0 and every nibble of seg_val from dig up to 7 is zero. Digit 0 is never blanked, so value 0 shows a single "0".
- Not defined: all eight digits are always lit.
- Scan timing is identical in both builds.

Test Plan:
- Reset: hold reset_n = 0 for 2 cycles, then release. Required:
  - led_out = 0, seg_an = FE, seg_out = C0
  - io_read at 0xFFFFFC70 gives r_rdata = 0
- IO write then read: io_write, addr 0xFFFFFC60, r_wdata 0x00ABCDEF. Then io_write, addr 0xFFFFFC80, r_wdata 0x12345678. Required:
  - led_out = ABCDEF after the first edge
  - io_read 0xFFFFFC80 next cycle gives 0x12345678
  - io_write to 0xFFFFFC90 leaves led_out unchanged
- Memory path: mem_read = 1, m_rdata = 0xDEADBEEF, addr 0x00000010. Required:
  - r_rdata = DEADBEEF, addr_out = 0x10
  - mem_write = 1, r_wdata = 0x55 gives write_data = 0x55
  - with mem_read = 0 and io_read = 0, r_rdata = 0
- Debounce (DEBOUNCE_CYCLES = 4): switch_in 0x000001 toggled with period 3 cycles, then held. Required:
  - sw_db stays 0 while toggling
  - sw_db = 1 exactly 2 + 4 cycles after switch_in stabilises
  - io_read 0xFFFFFC70 returns 0x00000001
- Scan (SCAN_DIV = 4, seg_val = 0x0000A05F). Required:
  - seg_an sequence FE, FD, FB, F7, EF, ... with 4 cycles per step
  - seg_out: 8E, 92, C0, 88 on digits 0..3
  - dig wraps 7 -> 0
  - with SEG_LEAD_ZERO_BLANK_EN, digits 4..7 give seg_an = FF
- Reset mid-operation: assert reset_n = 0 with dig = 5 and the debounce counter nonzero. Required: next cycle seg_an = FE, and counter and sw_db both 0.
